// File: rtl/tlp_pkt_stager.sv
// Store-and-forward stager: buffers one whole TLP from AXI-Stream, then writes it
// into the encapsulator FIFO as a single gap-free burst once the FIFO has room for all of it.
module tlp_pkt_stager #(
  parameter int max_words = 32,
  parameter int cnt_w     = 10
) (
  input  logic             clk156,
  input  logic             sys_rst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             wr_en,
  output logic [73:0]      din,
  input  logic             full,
  input  logic [cnt_w-1:0] wr_free,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int ptr_w = $clog2(max_words);
  localparam int len_w = $clog2(max_words + 1);
  localparam logic [ptr_w-1:0] last_slot = ptr_w'(max_words - 1);

  typedef enum logic [1:0] {ST_FILL, ST_DISCARD, ST_WAIT, ST_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [73:0]        r_buf [max_words];
  logic [ptr_w-1:0]   r_wptr;
  logic [len_w-1:0]   r_rptr;
  logic [len_w-1:0]   r_len;
  logic               r_wr_en;
  logic [73:0]        r_din;
  logic [15:0]        r_pkt_cnt;
  logic [15:0]        r_drop_cnt;

  logic               w_hs;
  logic               w_space;
  logic               w_last_word;
  logic [73:0]        w_rd_word;
  logic               w_store;
  logic               w_close;
  logic               w_overflow;
  logic               w_drop;
  logic               w_emit;
  logic               w_done;

  // Ready is held low while reset is asserted so no word is accepted into a stale packet.
  assign s_axis_tready = !sys_rst && (r_state == ST_FILL || r_state == ST_DISCARD);
  assign w_hs          = s_axis_tvalid && s_axis_tready;
  assign w_space       = (wr_free >= cnt_w'(r_len)) && !full;
  assign w_rd_word     = r_buf[r_rptr[ptr_w-1:0]];
  assign w_last_word   = (r_rptr == r_len - len_w'(1));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_close     = 1'b0;
    w_overflow  = 1'b0;
    w_drop      = 1'b0;
    w_emit      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (w_hs) begin
          if (s_axis_tlast) begin
            w_store     = 1'b1;
            w_close     = 1'b1;
            w_state_nxt = ST_WAIT;
          end else if (r_wptr == last_slot) begin
            w_overflow  = 1'b1;
            w_state_nxt = ST_DISCARD;
          end else begin
            w_store     = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (w_hs && s_axis_tlast) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      // The first word is loaded on the WAIT->DRAIN edge so wr_en rises the cycle the state enters DRAIN.
      ST_WAIT: begin
        if (w_space) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_rptr == r_len) begin
          w_done      = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_emit      = 1'b1;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      r_state    <= ST_FILL;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_len      <= '0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_emit;
      if (w_close) begin
        r_len  <= len_w'(r_wptr) + len_w'(1);
        r_wptr <= '0;
      end else if (w_overflow) begin
        r_wptr <= '0;
      end else if (w_store) begin
        r_wptr <= r_wptr + ptr_w'(1);
      end
      if (w_emit) begin
        r_din  <= {w_rd_word[73:2], w_last_word, w_rd_word[0]};
        r_rptr <= r_rptr + len_w'(1);
      end
      if (w_done) begin
        r_rptr <= '0;
        if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // NOTE: the packet buffer has no reset; contents are only read after being written for the current packet.
  always_ff @(posedge clk156) begin
    if (w_store) r_buf[r_wptr] <= {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};
  end

  assign wr_en    = r_wr_en;
  assign din      = r_din;
  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_tlp_pkt_stager.sv
// Bench for tlp_pkt_stager: table-driven packets, hand-built timing corner cases and random
// traffic, all scored against a packet-level model (whole packet in, forced-tlast burst out).
module tb_tlp_pkt_stager;
  localparam int max_words = 32;
  localparam int cnt_w     = 10;

  logic             clk156 = 1'b0;
  logic             sys_rst = 1'b1;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [63:0]      s_axis_tdata = '0;
  logic [7:0]       s_axis_tkeep = '0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tuser = 1'b0;
  logic             wr_en;
  logic [73:0]      din;
  logic             full = 1'b0;
  logic [cnt_w-1:0] wr_free = 10'd512;
  logic [15:0]      pkt_cnt;
  logic [15:0]      drop_cnt;

  tlp_pkt_stager #(.max_words(max_words), .cnt_w(cnt_w)) dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full), .wr_free(wr_free),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #3 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  logic [73:0] got_q[$];
  int          got_cyc[$];
  logic [73:0] exp_q[$];
  logic [73:0] pkt_q[$];
  int          exp_pkt = 0;
  int          exp_drop = 0;
  bit          overlap = 1'b0;
  int          hs_cyc;

  typedef struct {
    int n;
    int gap_pct;
    int exp_writes;
    int exp_pkt_inc;
    int exp_drop_inc;
  } vec_t;
  vec_t vecs[7];

  always @(negedge clk156) begin
    if (wr_en) begin
      got_q.push_back(din);
      got_cyc.push_back(cyc);
    end
    if (wr_en && s_axis_tready) overlap = 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got no completion want completion", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stopped early");
  endtask

  task automatic build_pkt(input int n);
    logic [7:0] k;
    pkt_q.delete();
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? 8'($urandom_range(255, 1)) : 8'hFF;
      pkt_q.push_back({k, $urandom, $urandom, (i == n - 1), 1'($urandom_range(1))});
    end
  endtask

  // Drives pkt_q word by word (optional idle gaps) and updates the packet-level model.
  task automatic send_pkt(input int gap_pct);
    int n;
    int budget;
    logic [73:0] w;
    n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk156);
      end
      {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser} = pkt_q[i];
      s_axis_tvalid = 1'b1;
      budget = 0;
      while (!s_axis_tready) begin
        @(negedge clk156);
        budget++;
        if (budget > 400) abort("ingress ready");
      end
      @(negedge clk156);
    end
    hs_cyc = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (n <= max_words) begin
      for (int i = 0; i < n; i++) begin
        w    = pkt_q[i];
        w[1] = (i == n - 1);
        exp_q.push_back(w);
      end
      exp_pkt++;
    end else begin
      exp_drop++;
    end
  endtask

  // Waits for the stage to return to idle, then scores every written word and both counters.
  task automatic drain(input string name, input int relax_after, output int nw, output int first_c,
                       output int last_c, output bit contig, output logic [73:0] last_w);
    int budget;
    budget = 0;
    while (!(s_axis_tready && got_q.size() >= exp_q.size())) begin
      @(negedge clk156);
      budget++;
      if (budget == relax_after) begin
        wr_free = 10'd512;
        full    = 1'b0;
      end
      if (budget > 600) abort(name);
    end
    nw      = got_q.size();
    first_c = (nw > 0) ? got_cyc[0] : -1;
    last_c  = (nw > 0) ? got_cyc[nw-1] : -1;
    last_w  = (nw > 0) ? got_q[nw-1] : '0;
    contig  = 1'b1;
    for (int i = 1; i < nw; i++) if (got_cyc[i] != got_cyc[0] + i) contig = 1'b0;
    check({name, " write count"}, nw, exp_q.size());
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
    check({name, " pkt_cnt"}, pkt_cnt, exp_pkt);
    check({name, " drop_cnt"}, drop_cnt, exp_drop);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int nw, fc, lc, base_pkt, base_drop, budget, c0;
    bit contig, rdy_seen;
    logic [73:0] lw;

    vecs[0] = '{1, 0, 1, 1, 0};
    vecs[1] = '{32, 0, 32, 1, 0};
    vecs[2] = '{33, 0, 0, 0, 1};
    vecs[3] = '{2, 0, 2, 1, 0};
    vecs[4] = '{6, 50, 6, 1, 0};
    vecs[5] = '{40, 25, 0, 0, 1};
    vecs[6] = '{17, 40, 17, 1, 0};

    // Reset values and ready behaviour around reset release.
    repeat (3) @(negedge clk156);
    check("reset tready", s_axis_tready, 1'b0);
    check("reset wr_en", wr_en, 1'b0);
    check("reset din", din, 74'd0);
    check("reset pkt_cnt", pkt_cnt, 16'd0);
    check("reset drop_cnt", drop_cnt, 16'd0);
    sys_rst = 1'b0;
    #1;
    check("tready after reset", s_axis_tready, 1'b1);
    @(negedge clk156);

    // 4-word packet: latency, contiguity, forced tlast and tkeep of the last word.
    pkt_q.delete();
    pkt_q.push_back({8'hFF, 64'h1111_0000_0000_0001, 1'b0, 1'b0});
    pkt_q.push_back({8'hFF, 64'h2222_0000_0000_0002, 1'b0, 1'b0});
    pkt_q.push_back({8'hFF, 64'h3333_0000_0000_0003, 1'b0, 1'b0});
    pkt_q.push_back({8'h0F, 64'h4444_0000_0000_0004, 1'b1, 1'b0});
    send_pkt(0);
    drain("pkt4", 1000, nw, fc, lc, contig, lw);
    check("pkt4 first wr_en cycle", fc, hs_cyc + 1);
    check("pkt4 last wr_en cycle", lc, hs_cyc + 4);
    check("pkt4 contiguous", contig, 1'b1);
    check("pkt4 last tkeep", lw[73:66], 8'h0F);
    check("pkt4 last tlast", lw[1], 1'b1);

    // Table of packet sizes including the max_words boundary and oversize drops.
    for (int v = 0; v < 7; v++) begin
      base_pkt  = exp_pkt;
      base_drop = exp_drop;
      build_pkt(vecs[v].n);
      send_pkt(vecs[v].gap_pct);
      drain($sformatf("vec%0d n%0d", v, vecs[v].n), 1000, nw, fc, lc, contig, lw);
      check($sformatf("vec%0d writes", v), nw, vecs[v].exp_writes);
      check($sformatf("vec%0d pkt inc", v), pkt_cnt, base_pkt + vecs[v].exp_pkt_inc);
      check($sformatf("vec%0d drop inc", v), drop_cnt, base_drop + vecs[v].exp_drop_inc);
      if (nw > 0) check($sformatf("vec%0d contiguous", v), contig, 1'b1);
    end

    // 8-word packet stalls at wr_free=7, bursts once wr_free=8, ignores full mid-burst.
    wr_free = 10'd7;
    build_pkt(8);
    send_pkt(0);
    rdy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk156);
      #1;
      if (s_axis_tready) rdy_seen = 1'b1;
    end
    check("stall no writes", got_q.size(), 0);
    check("stall tready low", rdy_seen, 1'b0);
    wr_free = 10'd8;
    c0 = cyc;
    budget = 0;
    while (got_q.size() < 3) begin
      @(negedge clk156);
      #1;
      budget++;
      if (budget > 50) abort("stall burst start");
    end
    full    = 1'b1;
    wr_free = 10'd0;
    drain("stall", 1000, nw, fc, lc, contig, lw);
    check("stall burst start cycle", fc, c0 + 1);
    check("stall burst length", lc - fc + 1, 8);
    check("stall contiguous", contig, 1'b1);
    full    = 1'b0;
    wr_free = 10'd512;

    // Random traffic with random gaps and occasional space stalls.
    for (int p = 0; p < 30; p++) begin
      wr_free = 10'($urandom_range(40, 1));
      full    = ($urandom_range(3) == 0);
      build_pkt($urandom_range(36, 1));
      send_pkt($urandom_range(60));
      drain($sformatf("rnd%0d", p), 15, nw, fc, lc, contig, lw);
      if (nw > 0) check($sformatf("rnd%0d contiguous", p), contig, 1'b1);
    end
    wr_free = 10'd512;
    full    = 1'b0;

    // Reset pulsed on the 3rd DRAIN cycle.
    build_pkt(8);
    send_pkt(0);
    budget = 0;
    while (got_q.size() < 3) begin
      @(negedge clk156);
      #1;
      budget++;
      if (budget > 50) abort("reset burst start");
    end
    sys_rst = 1'b1;
    @(negedge clk156);
    check("midrst wr_en", wr_en, 1'b0);
    check("midrst pkt_cnt", pkt_cnt, 16'd0);
    check("midrst drop_cnt", drop_cnt, 16'd0);
    check("midrst tready", s_axis_tready, 1'b0);
    sys_rst = 1'b0;
    #1;
    check("midrst tready release", s_axis_tready, 1'b1);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    @(negedge clk156);
    build_pkt(3);
    send_pkt(0);
    drain("post reset", 1000, nw, fc, lc, contig, lw);
    check("post reset first cycle", fc, hs_cyc + 1);
    check("post reset contiguous", contig, 1'b1);

    check("no ingress/egress overlap", overlap, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlp_pkt_stager.md
# tlp_pkt_stager

Store-and-forward staging stage placed directly upstream of the Ethernet/IP/UDP encapsulator's TLP FIFO. It accepts a 64-bit AXI-Stream of TLP packets, buffers each packet whole, and writes it into the FIFO as one uninterrupted burst. It writes only when the FIFO reports room for the entire packet. The encapsulator reads without checking `empty` once a packet has started, so this stage guarantees it never sees a partial packet. Oversized packets are discarded and counted.

## Interface
Parameters:
- `max_words`, 32: largest packet accepted, in 64-bit words (256 B); longer packets are dropped.
- `cnt_w`, 10: width of the FIFO free-entry count.

Ports:
- `clk156`  in  1  sole clock.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `s_axis_tvalid`  in  1  ingress word valid.
- `s_axis_tready`  out  1  ingress ready.
- `s_axis_tdata`  in  64  ingress data.
- `s_axis_tkeep`  in  8  ingress byte enables.
- `s_axis_tlast`  in  1  last word of packet.
- `s_axis_tuser`  in  1  per-word error flag from source.
- `wr_en`  out  1  FIFO write strobe.
- `din`  out  74  FIFO word `{tkeep[73:66], tdata[65:2], tlast[1], tuser[0]}`.
- `full`  in  1  FIFO full.
- `wr_free`  in  `cnt_w`  FIFO free entries, valid every cycle.
- `pkt_cnt`  out  16  packets written to FIFO, saturating.
- `drop_cnt`  out  16  oversized packets discarded, saturating.

## Operation
- Internal buffer: `max_words` x 74 bits, write pointer `wptr`, read pointer `rptr`, stored length `len` (1..`max_words`).
- FSM states: `FILL`, `DISCARD`, `WAIT`, `DRAIN`.
- `FILL` (`s_axis_tready` = 1):
  - Each handshake stores `{tkeep, tdata, tlast, tuser}` at `wptr`, then increments `wptr`.
  - Handshake with `tlast` = 1: set `len` = `wptr` + 1, clear `wptr`, go to `WAIT`.
  - Handshake with `tlast` = 0 at `wptr` = `max_words`-1: go to `DISCARD`. `wptr` clears and nothing is stored.
- `DISCARD` (`s_axis_tready` = 1): consume words with no storage. On the `tlast` handshake, increment `drop_cnt` and go to `FILL`.
- `WAIT` (`s_axis_tready` = 0): when `wr_free` >= `len` and `full` = 0, clear `rptr` and go to `DRAIN`.
- `DRAIN` (`s_axis_tready` = 0):
  - Emit one word per cycle from `buf[rptr]` with `wr_en` = 1, and increment `rptr`.
  - The tlast bit of `din` is forced to 1 on word `len`-1 and to 0 on all other words. tkeep, tdata and tuser pass through unmodified.
  - After word `len`-1: increment `pkt_cnt` and go to `FILL`.
  - `full` and `wr_free` are ignored during `DRAIN`; space was reserved in `WAIT`.
- A packet of exactly `max_words` words (tlast on word `max_words`-1) is accepted, not dropped.
- Both counters saturate at 16'hFFFF.

## Timing
- Reset:
  - State `FILL`; `wptr`, `rptr`, `len` = 0.
  - `wr_en` = 0, `din` = 0, `pkt_cnt` = 0, `drop_cnt` = 0.
  - `s_axis_tready` = 0 during every reset cycle and 1 on the first cycle after reset.
- `wr_en` and `din` are registered outputs; `din` is valid only when `wr_en` = 1 and holds its last value otherwise.
- Latency: `tlast` handshake at cycle T puts the FSM in `WAIT` at T+1. If the space check passes at T+1, the first `wr_en` is at T+2 and the last is at T+1+`len`. `FILL` resumes at T+2+`len`.
- During `DRAIN`, `wr_en` is asserted for exactly `len` consecutive cycles with no gaps.
- No overlap between ingress and egress: `s_axis_tready` and `wr_en` are never both 1.
- `WAIT` re-checks the space condition every cycle and stalls indefinitely while it is false.
- `sys_rst` asserted mid-`DRAIN` or mid-`FILL`: the next cycle is in reset state, and the partial packet is lost with no counter update. The FIFO itself is reset by the same `sys_rst`.

## Test plan
- 4-word packet (tkeep FF,FF,FF,0F; tuser 0), `wr_free` = 512 -> `wr_en` high for 4 consecutive cycles starting 2 cycles after the tlast handshake. `din` tlast bits 0,0,0,1; `din[73:66]` of the last word = 8'h0F; `pkt_cnt` = 1.
- 1-word packet -> single `wr_en` pulse with tlast = 1.
- 32-word packet -> accepted, 32 writes; a 33-word packet -> zero writes, `drop_cnt` = 1, and the next packet is written normally.
- 8-word packet with `wr_free` held at 7 for 20 cycles, then 8 -> no `wr_en` while `wr_free` = 7. The burst starts on the cycle after `wr_free` reaches 8 and runs 8 cycles unbroken even if `full` rises mid-burst.
- `s_axis_tvalid` toggling 1/0 within a packet -> stored words are contiguous and the written data matches input order; `s_axis_tready` = 0 throughout `WAIT`/`DRAIN`.
- `sys_rst` pulsed on the 3rd `DRAIN` cycle -> `wr_en` = 0 the next cycle, counters 0, and the following packet is handled normally.
